// File: rtl/mmio_timer_if.sv
`default_nettype none
// ============================================================================
// Module      : mmio_timer_if
// Description : Processor-side memory bus bundle for the mmio_timer block.
//               The master (processor/testbench) drives the word address,
//               write data and write strobe. The slave (timer) returns
//               registered read data, the registered address-hit flag that
//               steers the system DIN mux, and the interrupt request.
//   addr  [15:0] word address (from processor ADDR register)
//   wdata [15:0] write data (from processor DOUT register)
//   w            write strobe
//   rdata [15:0] registered read data
//   hit          registered: previous-cycle addr was in range
//   irq          interrupt request
// Revision    : 1.0 - initial release
// ============================================================================
interface mmio_timer_if;
    logic [15:0] addr;
    logic [15:0] wdata;
    logic        w;
    logic [15:0] rdata;
    logic        hit;
    logic        irq;

    modport master (
        output addr,
        output wdata,
        output w,
        input  rdata,
        input  hit,
        input  irq
    );

    modport slave (
        input  addr,
        input  wdata,
        input  w,
        output rdata,
        output hit,
        output irq
    );
endinterface
`default_nettype wire

// File: rtl/mmio_timer.sv
`default_nettype none
// ============================================================================
// Module      : mmio_timer
// Description : Memory-mapped 16-bit interval timer with one-shot and
//               continuous modes, sticky timeout flag, counter snapshot and
//               interrupt output. Read data is registered (one cycle latency).
//   clk_i        system clock, rising edge
//   rst_i        asynchronous active-high reset
//   bus (slave)  addr/wdata/w in, rdata/hit/irq out
//   Register map (offset = addr[1:0]):
//     0 STATUS  R: {14'b0, RUN, TO}        W: clear TO
//     1 CONTROL R: {12'b0, ITO, 2'b0, CONT} W: b0 CONT, b1 START, b2 STOP, b3 ITO
//     2 PERIOD  R/W reload value
//     3 SNAP    R: snapshot                 W: capture COUNT
// Revision    : 1.0 - initial release
// ============================================================================
module mmio_timer #(
    parameter logic [15:0] BASE_ADDR    = 16'h5000,
    parameter logic [15:0] RESET_PERIOD = 16'd0
) (
    input  wire logic     clk_i,
    input  wire logic     rst_i,
    mmio_timer_if.slave   bus
);

    localparam logic [13:0] BASE_WORD = BASE_ADDR[15:2];

    // Registered state
    logic [15:0] count_q,  count_d;
    logic [15:0] period_q, period_d;
    logic [15:0] snap_q,   snap_d;
    logic        run_q,    run_d;
    logic        to_q,     to_d;
    logic        cont_q,   cont_d;
    logic        ito_q,    ito_d;
    logic [15:0] rdata_q,  rdata_d;
    logic        hit_q,    hit_d;

    // Decode
    logic        hit_now;
    logic [1:0]  off;
    logic        wr;
    logic        wr_status;
    logic        wr_ctrl;
    logic        wr_period;
    logic        wr_snap;
    logic        start;
    logic        stop;
    logic        expire;

    assign hit_now   = (bus.addr[15:2] == BASE_WORD);
    assign off       = bus.addr[1:0];
    assign wr        = bus.w & hit_now;
    assign wr_status = wr & (off == 2'd0);
    assign wr_ctrl   = wr & (off == 2'd1);
    assign wr_period = wr & (off == 2'd2);
    assign wr_snap   = wr & (off == 2'd3);
    assign start     = wr_ctrl & bus.wdata[1];
    assign stop      = wr_ctrl & bus.wdata[2];
    assign expire    = run_q & (count_q == 16'd0);

    always_comb begin
        count_d  = count_q;
        run_d    = run_q;
        to_d     = to_q;
        cont_d   = cont_q;
        ito_d    = ito_q;
        period_d = period_q;
        snap_d   = snap_q;
        rdata_d  = 16'h0000;
        hit_d    = hit_now;

        // Read path samples pre-edge register contents; a write cycle
        // therefore returns the old value.
        if (hit_now) begin
            case (off)
                2'd0:    rdata_d = {14'b0, run_q, to_q};
                2'd1:    rdata_d = {12'b0, ito_q, 2'b0, cont_q};
                2'd2:    rdata_d = period_q;
                default: rdata_d = snap_q;
            endcase
        end

        if (wr_ctrl) begin
            cont_d = bus.wdata[0];
            ito_d  = bus.wdata[3];
        end
        if (wr_period) begin
            period_d = bus.wdata;
        end
        // Snapshot takes COUNT as it was before this edge's decrement.
        if (wr_snap) begin
            snap_d = count_q;
        end

        // Expiry sets TO even when START/STOP win the counter; set beats
        // a concurrent STATUS clear.
        if (expire) begin
            to_d = 1'b1;
        end else if (wr_status) begin
            to_d = 1'b0;
        end

        if (stop) begin
            run_d = 1'b0;
        end else if (start) begin
            run_d   = 1'b1;
            count_d = period_q;
        end else if (expire) begin
            if (cont_q) begin
                count_d = period_q;
            end else begin
                run_d = 1'b0;
            end
        end else if (run_q) begin
            count_d = count_q - 16'd1;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            count_q  <= 16'd0;
            period_q <= RESET_PERIOD;
            snap_q   <= 16'd0;
            run_q    <= 1'b0;
            to_q     <= 1'b0;
            cont_q   <= 1'b0;
            ito_q    <= 1'b0;
            rdata_q  <= 16'd0;
            hit_q    <= 1'b0;
        end else begin
            count_q  <= count_d;
            period_q <= period_d;
            snap_q   <= snap_d;
            run_q    <= run_d;
            to_q     <= to_d;
            cont_q   <= cont_d;
            ito_q    <= ito_d;
            rdata_q  <= rdata_d;
            hit_q    <= hit_d;
        end
    end

    assign bus.rdata = rdata_q;
    assign bus.hit   = hit_q;
    assign bus.irq   = to_q & ito_q;

endmodule
`default_nettype wire

// File: tb/tb_mmio_timer.sv
`default_nettype none
// ============================================================================
// Module      : tb_mmio_timer
// Description : Self-checking bench for mmio_timer. A behavioural model of
//               the register file and counter tracks every edge; a compare
//               process checks rdata/hit/irq each cycle. Directed sequences
//               pin the model with literal expectations, then randomized
//               bus traffic runs against the model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mmio_timer;

    localparam logic [15:0] BASE   = 16'h5000;
    localparam logic [15:0] RST_PER = 16'h0003;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    mmio_timer_if bus ();

    mmio_timer #(
        .BASE_ADDR    (BASE),
        .RESET_PERIOD (RST_PER)
    ) dut (
        .clk_i (clk),
        .rst_i (rst),
        .bus   (bus)
    );

    int n_pass  = 0;
    int n_total = 0;
    bit cmp_en  = 1'b0;

    // ---------------- behavioural model ----------------
    int          m_count, m_period, m_snap;
    bit          m_run, m_to, m_cont, m_ito;
    logic [15:0] m_rdata;
    bit          m_hit;
    int          m_old_count;
    bit          t_hit, t_wr, t_start, t_stop, t_exp;
    int          t_off;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_count = 0; m_period = RST_PER; m_snap = 0;
            m_run = 0; m_to = 0; m_cont = 0; m_ito = 0;
            m_rdata = 16'h0; m_hit = 0;
        end else begin
            t_hit = (bus.addr / 4) == (BASE / 4);
            t_off = bus.addr % 4;
            t_wr  = bus.w && t_hit;
            // Reads see the state before this edge.
            if (!t_hit)          m_rdata = 16'h0;
            else if (t_off == 0) m_rdata = 16'(m_run * 2 + m_to);
            else if (t_off == 1) m_rdata = 16'(m_ito * 8 + m_cont);
            else if (t_off == 2) m_rdata = 16'(m_period);
            else                 m_rdata = 16'(m_snap);
            m_hit = t_hit;

            t_start = t_wr && t_off == 1 && bus.wdata[1];
            t_stop  = t_wr && t_off == 1 && bus.wdata[2];
            t_exp   = m_run && m_count == 0;
            m_old_count = m_count;

            // Counter: stop, else start, else expiry, else tick.
            if (t_stop)       m_run = 0;
            else if (t_start) begin m_run = 1; m_count = m_period; end
            else if (t_exp) begin
                if (m_cont) m_count = m_period;
                else        m_run = 0;
            end else if (m_run) m_count = m_count - 1;

            if (t_exp)                      m_to = 1;
            else if (t_wr && t_off == 0)    m_to = 0;
            if (t_wr && t_off == 1) begin
                m_cont = bus.wdata[0];
                m_ito  = bus.wdata[3];
            end
            if (t_wr && t_off == 2) m_period = bus.wdata;
            if (t_wr && t_off == 3) m_snap   = m_old_count;
        end
    end

    // ---------------- compare process ----------------
    always @(negedge clk) begin
        if (cmp_en) begin
            n_total++;
            if (bus.rdata === m_rdata && bus.hit === m_hit &&
                bus.irq === (m_to && m_ito)) begin
                n_pass++;
            end else begin
                $display("FAIL model t=%0t: got rdata=%h hit=%b irq=%b, expected rdata=%h hit=%b irq=%b",
                         $time, bus.rdata, bus.hit, bus.irq, m_rdata, m_hit, m_to && m_ito);
            end
        end
    end

    // ---------------- helpers ----------------
    task automatic lit(input string name, input logic [15:0] act, input logic [15:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    // Apply inputs at a falling edge; return at the next falling edge, when
    // the outputs reflect the rising edge that consumed them.
    task automatic cyc(input logic [15:0] a, input logic [15:0] d, input logic w);
        bus.addr  = a;
        bus.wdata = d;
        bus.w     = w;
        @(negedge clk);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cyc(BASE, 16'h0, 1'b0);
    endtask

    logic [15:0] ra, rd;
    int          r;

    initial begin
        bus.addr = 16'h0; bus.wdata = 16'h0; bus.w = 1'b0;
        #1 rst = 1'b1;
        repeat (2) @(negedge clk);
        lit("reset_rdata", bus.rdata, 16'h0);
        lit("reset_hit",   {15'b0, bus.hit}, 16'h0);
        lit("reset_irq",   {15'b0, bus.irq}, 16'h0);
        rst = 1'b0;
        cmp_en = 1'b1;

        cyc(BASE + 2, 16'h0, 1'b0);
        lit("reset_period", bus.rdata, RST_PER);

        // One-shot, PERIOD=5, START at edge 0
        cyc(BASE + 2, 16'd5, 1'b1);
        cyc(BASE + 1, 16'h0002, 1'b1);      // edge 0
        idle(5);                             // edges 1..5
        cyc(BASE, 16'h0, 1'b0);              // edge 6 (reads pre-edge)
        lit("oneshot_status_e6", bus.rdata, 16'h0002);
        cyc(BASE, 16'h0, 1'b0);              // edge 7
        lit("oneshot_status_e7", bus.rdata, 16'h0001);
        cyc(BASE + 3, 16'h0, 1'b1);
        cyc(BASE + 3, 16'h0, 1'b0);
        lit("oneshot_snap", bus.rdata, 16'h0000);

        // Continuous + interrupt
        cyc(BASE + 1, 16'h0004, 1'b1);
        cyc(BASE, 16'h0, 1'b1);
        cyc(BASE + 2, 16'd3, 1'b1);
        cyc(BASE + 1, 16'h000B, 1'b1);      // edge 0
        idle(3);                             // edges 1..3
        lit("cont_irq_e3", {15'b0, bus.irq}, 16'h0);
        idle(1);                             // edge 4
        lit("cont_irq_e4", {15'b0, bus.irq}, 16'h1);
        idle(1);                             // edge 5
        cyc(BASE, 16'h0, 1'b1);              // edge 6: clear TO
        lit("cont_irq_e6", {15'b0, bus.irq}, 16'h0);
        idle(1);                             // edge 7
        lit("cont_irq_e7", {15'b0, bus.irq}, 16'h0);
        idle(1);                             // edge 8
        lit("cont_irq_e8", {15'b0, bus.irq}, 16'h1);

        // Clear / expire collision
        cyc(BASE + 1, 16'h0004, 1'b1);
        cyc(BASE, 16'h0, 1'b1);
        cyc(BASE + 2, 16'd2, 1'b1);
        cyc(BASE + 1, 16'h0002, 1'b1);      // edge 0
        idle(2);                             // edges 1..2
        cyc(BASE, 16'h0, 1'b1);              // edge 3: expiry + clear
        cyc(BASE, 16'h0, 1'b0);
        lit("collision_status", bus.rdata, 16'h0001);

        // Stop+start while COUNT=7
        cyc(BASE + 2, 16'd20, 1'b1);
        cyc(BASE + 1, 16'h0002, 1'b1);      // edge 0, COUNT=20
        idle(13);                            // COUNT=7
        cyc(BASE + 1, 16'h0006, 1'b1);
        cyc(BASE + 3, 16'h0, 1'b1);
        cyc(BASE + 3, 16'h0, 1'b0);
        lit("stopstart_snap", bus.rdata, 16'h0007);
        cyc(BASE, 16'h0, 1'b0);
        lit("stopstart_status", bus.rdata, 16'h0001);

        // Decode and read latency
        cyc(BASE + 4, 16'h0, 1'b0);
        lit("oor_hit",   {15'b0, bus.hit}, 16'h0);
        lit("oor_rdata", bus.rdata, 16'h0);
        cyc(BASE + 2, 16'hABCD, 1'b1);
        cyc(BASE + 2, 16'h0, 1'b0);
        lit("period_rd", bus.rdata, 16'hABCD);
        cyc(BASE + 6, 16'h1234, 1'b1);
        cyc(BASE - 2, 16'h5678, 1'b1);
        cyc(BASE + 2, 16'h0, 1'b0);
        lit("oor_write", bus.rdata, 16'hABCD);

        // Asynchronous reset mid-count
        cyc(BASE + 2, 16'd20, 1'b1);
        cyc(BASE + 1, 16'h000A, 1'b1);      // edge 0, COUNT=20
        idle(11);                            // COUNT=9
        lit("pre_rst_irq", {15'b0, bus.irq}, 16'h1);
        #2 rst = 1'b1;
        #1;
        lit("async_rdata", bus.rdata, 16'h0);
        lit("async_hit",   {15'b0, bus.hit}, 16'h0);
        lit("async_irq",   {15'b0, bus.irq}, 16'h0);
        #1 rst = 1'b0;
        @(negedge clk);
        idle(15);
        lit("post_rst_status", bus.rdata, 16'h0000);

        // Randomized traffic
        for (int i = 0; i < 3000; i++) begin
            r  = $urandom_range(0, 9);
            ra = (r < 8) ? BASE + 16'($urandom_range(0, 3)) : 16'($urandom);
            case (ra[1:0])
                2'd1:    rd = {12'h0, 1'($urandom), ($urandom_range(0, 7) == 0), 1'($urandom), 1'($urandom)};
                2'd2:    rd = 16'($urandom_range(0, 11));
                default: rd = 16'($urandom);
            endcase
            cyc(ra, rd, ($urandom_range(0, 9) < 4));
        end

        cmp_en = 1'b0;
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/mmio_timer.md
Name: mmio_timer

Overview:
- Memory-mapped interval timer. It sits directly downstream of the processor's memory bus (ADDR, DOUT, W) and returns read data on the processor's DIN path through the system read mux.
- Read data is registered with one cycle of latency, so it behaves like the synchronous memory the processor already waits on (fetch T1, ld T4).
- The block provides a programmable 16-bit down-counter with one-shot and continuous modes, a sticky timeout flag, a counter snapshot, and an interrupt output.

Parameters:
- BASE_ADDR, 16'h5000: word address of register 0. Must be 4-aligned (BASE_ADDR[1:0] = 0).
- RESET_PERIOD, 16'd0: PERIOD register value after reset.

Ports:
- Clock  input  1  system clock; all state changes on rising edge.
- Reset  input  1  asynchronous, active-high reset.
- ADDR  input  16  word address from processor ADDR register.
- WDATA  input  16  write data from processor DOUT register.
- W  input  1  write strobe from processor W flip-flop.
- RDATA  output  16  registered read data to system DIN mux.
- Hit  output  1  registered: previous-cycle ADDR was in this block's range; drives the DIN mux select.
- Irq  output  1  interrupt request = TO & ITO.

Behaviour:
- Interface: one clock; reset is asynchronous and active-high.
- Address decode: hit_now = (ADDR[15:2] == BASE_ADDR[15:2]). off = ADDR[1:0].
- Write: occurs on the edge where W=1 and hit_now, using WDATA. Writes with hit_now=0 are ignored.
- Register map by offset:
  - 0 STATUS:
    - Read: {14'b0, RUN, TO}.
    - Write (any data): clears TO.
  - 1 CONTROL:
    - Read: {12'b0, ITO, 2'b0, CONT}.
    - Write bit0 loads CONT; bit3 loads ITO.
    - Write bit1 = START, bit2 = STOP (pulses, not stored).
  - 2 PERIOD: read/write 16-bit reload value.
  - 3 SNAP:
    - Write (any data): captures COUNT into SNAP.
    - Read: returns SNAP.
- Read: every cycle, RDATA <= hit_now ? reg[off] : 16'h0 and Hit <= hit_now.
  - Read values reflect register contents before that edge's updates.
  - W does not suppress the read; a write cycle returns the old value.
- Counter, per edge, in priority order:
  1. STOP written (with or without START): RUN <= 0; COUNT holds.
  2. START written: RUN <= 1; COUNT <= PERIOD (the PERIOD value before this edge).
  3. RUN=1 and COUNT=0 (expiry): TO <= 1. If CONT=1, COUNT <= PERIOD; otherwise RUN <= 0 and COUNT stays 0.
  4. RUN=1 and COUNT≠0: COUNT <= COUNT - 1.
  5. Otherwise COUNT holds.
- Expiry with START or STOP in the same edge:
  - Expiry still sets TO if RUN=1 and COUNT=0 at that edge.
  - COUNT and RUN follow START or STOP.
- Timing:
  - With START at edge 0 and PERIOD=N, TO rises at edge N+1.
  - In continuous mode the period is N+1 cycles.
  - PERIOD=0 with CONT=1 gives TO on every edge.
- TO clear vs. set: a STATUS write and an expiry in the same edge leave TO=1 (set wins).
- PERIOD write while running: no effect on the current COUNT; used at the next reload or START.
- SNAP capture takes COUNT before that edge's decrement.
- Wrap-around: COUNT never decrements below 0; there is no underflow path.
- Irq: combinational AND of the TO and ITO flops (glitch-free, both registered).
- Reset (asynchronous, at any time, including mid-count): forces the following immediately, independent of Clock:
  - COUNT = 0, SNAP = 0, PERIOD = RESET_PERIOD.
  - RUN = 0, TO = 0, CONT = 0, ITO = 0.
  - RDATA = 0, Hit = 0, Irq = 0.
- After reset deassertion, the first edge behaves normally.

Test Plan:
- One-shot: write PERIOD=5, then CONTROL=16'h0002 at edge 0.
  - TO=1 and RUN=0 after edge 6; COUNT stays 0.
  - STATUS read returns 16'h0001 on RDATA one cycle after ADDR.
- Continuous + interrupt: PERIOD=3, CONTROL=16'h000B.
  - Irq rises after edge 4.
  - Write STATUS at edge 6: Irq drops after edge 6.
  - TO re-sets after edge 8 (period of 4 cycles).
- Clear/expire collision: PERIOD=2, START at edge 0, STATUS write at edge 3 (expiry edge) -> TO=1 after edge 3.
- Stop vs. start: CONTROL=16'h0006 while running with COUNT=7 -> RUN=0, COUNT=7. SNAP write then read returns 16'h0007.
- Decode and read latency:
  - Read at ADDR = BASE_ADDR+4 -> Hit=0 and RDATA=16'h0000 the next cycle.
  - Write PERIOD=16'hABCD then read offset 2 -> RDATA=16'hABCD exactly one cycle after ADDR.
  - Writes with an out-of-range ADDR change nothing.
- Async reset mid-count: assert Reset between clock edges with RUN=1, COUNT=9, ITO=1, TO=1.
  - All outputs go to 0 before the next edge.
  - After release, no expiry occurs without a new START.
